// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: state encodings and
// word/byte sizing helpers used by the loader and its byte assembler.
package program_loader_pkg;

  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_RECV  = 3'd1;
  localparam logic [2:0] ENC_WRITE = 3'd2;
  localparam logic [2:0] ENC_DONE  = 3'd3;
  localparam logic [2:0] ENC_ERROR = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ENC_IDLE,
    ST_RECV  = ENC_RECV,
    ST_WRITE = ENC_WRITE,
    ST_DONE  = ENC_DONE,
    ST_ERROR = ENC_ERROR
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  // One extra bit so a full-depth count fits without wrapping.
  function automatic int word_index_width(input int memory_depth);
    return $clog2(memory_depth) + 1;
  endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Little-endian byte-to-word assembler: byte b of a word lands in bits
// [8*b+7:8*b]; the counter wraps to 0 on the last byte of each word.
module loader_byte_assembler
  import program_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_accept,
  input  logic                  i_clear,
  input  logic [7:0]            i_byte,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_last
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BPW - 1);

  logic [CW-1:0]         r_byte_cnt;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  w_last;

  assign w_last = (r_byte_cnt == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_cnt <= '0;
      r_word     <= '0;
    end else if (i_clear) begin
      r_byte_cnt <= '0;
    end else if (i_accept) begin
      for (int b = 0; b < BPW; b++) begin
        if (r_byte_cnt == CW'(b)) r_word[8*b +: 8] <= i_byte;
      end
      r_byte_cnt <= w_last ? '0 : r_byte_cnt + CW'(1);
    end
  end

  assign o_word = r_word;
  assign o_last = w_last;

endmodule

// File: rtl/program_loader.sv
// Boot loader: streams bytes into little-endian words, writes them to program
// memory at word_index*4, and holds the core in reset until the load is done.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start_i,
  input  logic [15:0]           Word_Count_i,
  input  logic [7:0]            Byte_i,
  input  logic                  Byte_Valid_i,
  output logic                  Byte_Ready_o,
  output logic                  Write_Enable_o,
  output logic [DATA_WIDTH-1:0] Write_Address_o,
  output logic [DATA_WIDTH-1:0] Write_Data_o,
  output logic                  Cpu_Hold_o,
  output logic                  Busy_o,
  output logic                  Done_o,
  output logic                  Error_o,
  output logic [2:0]            Dbg_State_o
);

  localparam int IW = word_index_width(MEMORY_DEPTH);

  // Byte handshake: a byte transfers on a rising edge where Byte_Valid_i and
  // Byte_Ready_o are both high; the source holds Byte_i until then.

  state_t                r_state, w_next_state;
  logic [IW-1:0]         r_word_index;
  logic [IW-1:0]         r_last_idx;
  logic [DATA_WIDTH-1:0] r_write_address;
  logic [DATA_WIDTH-1:0] w_addr_next;
  logic [DATA_WIDTH-1:0] w_word;
  logic [15:0]           w_count_m1;
  logic                  w_can_start, w_start_bad, w_clear;
  logic                  w_accept, w_last_byte, w_last_word;
  logic                  w_byte_ready, w_write_en, w_hold, w_busy, w_done, w_error;

  assign w_can_start = Start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                   (r_state == ST_ERROR));
  assign w_start_bad = (Word_Count_i == 16'd0) || (Word_Count_i > 16'(MEMORY_DEPTH));
  assign w_clear     = w_can_start && !w_start_bad;
  assign w_count_m1  = Word_Count_i - 16'd1;
  assign w_accept    = (r_state == ST_RECV) && Byte_Valid_i;
  assign w_last_word = (r_word_index == r_last_idx);

  always_comb begin
    w_addr_next = '0;
    w_addr_next[IW+1:0] = {r_word_index, 2'b00};
  end

  loader_byte_assembler #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_assembler (
    .clk      (clk),
    .reset    (reset),
    .i_accept (w_accept),
    .i_clear  (w_clear),
    .i_byte   (Byte_i),
    .o_word   (w_word),
    .o_last   (w_last_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_byte_ready = 1'b0;
    w_write_en   = 1'b0;
    w_hold       = 1'b1;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_error      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (Start_i) w_next_state = w_start_bad ? ST_ERROR : ST_RECV;
        w_done  = (r_state == ST_DONE);
        w_hold  = (r_state != ST_DONE);
        w_error = (r_state == ST_ERROR);
      end
      ST_RECV: begin
        w_byte_ready = 1'b1;
        w_busy       = 1'b1;
        if (w_accept && w_last_byte) w_next_state = ST_WRITE;
      end
      ST_WRITE: begin
        w_write_en   = 1'b1;
        w_busy       = 1'b1;
        w_next_state = w_last_word ? ST_DONE : ST_RECV;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Address is captured with the last byte so it is stable for the whole
  // write cycle and then held through DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word_index    <= '0;
      r_last_idx      <= '0;
      r_write_address <= '0;
    end else begin
      if (w_clear) begin
        r_word_index <= '0;
        r_last_idx   <= w_count_m1[IW-1:0];
      end
      if (w_accept && w_last_byte) r_write_address <= w_addr_next;
      if ((r_state == ST_WRITE) && !w_last_word) r_word_index <= r_word_index + IW'(1);
    end
  end

  assign Byte_Ready_o    = w_byte_ready;
  assign Write_Enable_o  = w_write_en;
  assign Write_Address_o = r_write_address;
  assign Write_Data_o    = w_word;
  assign Cpu_Hold_o      = w_hold;
  assign Busy_o          = w_busy;
  assign Done_o          = w_done;
  assign Error_o         = w_error;
  assign Dbg_State_o     = r_state;

endmodule
